mux_n_pipe: RTL and testbench
=============================

Name: mux_n_pipe

Overview:
Parametrised N-way, W-bit datapath selector with a registered output stage and a valid/ready handshake. It is the next generation of the fixed 5-input 32-bit selector used between register file, ALU and memory. The selector can be taken directly per transfer or latched once and held across a multicycle instruction. One output register decouples selector timing from downstream consumers such as the ALU operand and PC-source paths.

Parameters:
W, 32, data width in bits (>=1)
N, 5, number of data inputs (2..16)
SW, $clog2(N), selector width (derived; not overridden)
DEFAULT_VAL, 0, value driven for an out-of-range selector

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-low reset
in_data  input  N*W  packed inputs; input k occupies bits [k*W +: W]
sel  input  SW  binary selector, used directly when sel_hold=0
sel_load  input  1  pulse; latches sel into internal sel_q
sel_hold  input  1  1: use sel_q; 0: use sel
in_valid  input  1  upstream offers a transfer
in_ready  output  1  block can accept a transfer this cycle
out_data  output  W  registered selected value
out_valid  output  1  out_data holds an unconsumed value
out_ready  input  1  downstream accepts out_data
out_sel  output  SW  effective selector that produced out_data
sel_err  output  1  sticky out-of-range flag (see Optional Feature)

Behaviour:
- Reset (reset=0, asynchronous): out_data=DEFAULT_VAL, out_valid=0, out_sel=0, sel_q=0, sel_err=0. While in reset, in_ready=0.
- Effective selector: eff_sel = sel_hold ? sel_q : sel.
- sel_load=1 at a clock edge: sel_q<=sel.
- If sel_load=1 and sel_hold=1 in the same cycle, that cycle uses the old sel_q. The new value applies from the next cycle.
- in_ready = !out_valid || out_ready. This is combinational and gives full throughput of one transfer per cycle.
- Accept = in_valid && in_ready. On accept: out_data<=in_data[eff_sel], out_sel<=eff_sel, out_valid<=1. Latency is exactly 1 cycle, accept edge to out_valid.
- No accept and out_ready=1: out_valid<=0. out_data and out_sel keep their values.
- No accept and out_ready=0: all outputs hold. Stall-stable: out_data must not change while out_valid=1 && out_ready=0.
- Simultaneous consume and accept: out_valid stays 1 and out_data updates. No bubble.
- Out-of-range eff_sel (eff_sel>=N, only possible when N is not a power of 2): the transfer is still accepted with out_data=DEFAULT_VAL. It is never X and never aliases another input.
- Control state is only sel_q plus the output-register valid bit. Two states: EMPTY (out_valid=0) and FULL (out_valid=1), with transitions as above.
- A reset asserted mid-stall drops the pending value; nothing is replayed after release.

Optional Feature:
Macro MUX_SEL_CHECK_EN.
- Defined: any accepted transfer with eff_sel>=N sets sel_err<=1. The flag is sticky until reset. An out-of-range sel_load also sets it.
- Not defined: sel_err is tied to 0. DEFAULT_VAL substitution is unchanged.

Decomposition:
- Shared package mux_pkg: selector-width helper function (clog2), a DEFAULT_VAL constant, and named selector codes for the datapath muxes (e.g. PC source, ALU source A/B).
- One sub-module, mux_n_comb: purely combinational N-way W-bit selector with DEFAULT_VAL on out-of-range. mux_n_pipe instantiates it and adds sel_q, the handshake and the output register.

Test Plan:
- Reset: hold reset=0 while driving all inputs -> out_valid=0, out_data=0, in_ready=0. Release reset -> in_ready=1.
- Direct select: N=5, W=32, inputs k=0x1000_0000+k, sel=3, in_valid=1 for one cycle -> next cycle out_data=0x1000_0003, out_valid=1, out_sel=3.
- Back-to-back with stall: sel=0,1,2 on consecutive cycles; out_ready=0 during the second output -> out_data holds 0x1000_0001 and in_ready=0. Release -> 0x1000_0002 follows with no loss or duplication.
- Latched select: sel=4, sel_load=1; then sel_hold=1, sel=0 for 3 transfers -> all three out_data=0x1000_0004, out_sel=4.
- Out-of-range: N=5, sel=6, accept -> out_data=DEFAULT_VAL. With MUX_SEL_CHECK_EN, sel_err=1 and stays 1 after later valid selects until reset. Without the macro, sel_err=0.
- Reset mid-stall: out_valid=1, out_ready=0, then pulse reset low asynchronously between edges -> out_valid=0 immediately and sel_q=0.

Source files
------------

// File: rtl/mux_n_pipe_pkg.sv
// Shared definitions for the datapath selectors: selector-width helper,
// default substitution value, selector codes and the output-stage states.
package mux_pkg;

    localparam int DEFAULT_VAL_C = 0;

    // Selector width for an n-way mux; never narrower than one bit.
    function automatic int sel_width(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) w++;
        return w;
    endfunction

    typedef enum logic [1:0] {
        PC_SRC_SEQ    = 2'd0,
        PC_SRC_BRANCH = 2'd1,
        PC_SRC_JUMP   = 2'd2,
        PC_SRC_TRAP   = 2'd3
    } pc_src_e;

    typedef enum logic [2:0] {
        ALU_A_RS1  = 3'd0,
        ALU_A_PC   = 3'd1,
        ALU_A_ZERO = 3'd2
    } alu_a_e;

    typedef enum logic [2:0] {
        ALU_B_RS2  = 3'd0,
        ALU_B_IMM  = 3'd1,
        ALU_B_FOUR = 3'd2,
        ALU_B_CSR  = 3'd3,
        ALU_B_MEM  = 3'd4
    } alu_b_e;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } pipe_state_e;

endpackage

// File: rtl/mux_n_pipe_if.sv
// Handshake and data bundle for mux_n_pipe; master drives inputs, slave is the selector.
interface mux_n_pipe_if
    import mux_pkg::*;
#(
    parameter int W = 32,
    parameter int N = 5
);
    localparam int SW = sel_width(N);

    logic [N*W-1:0] in_data;
    logic [SW-1:0]  sel;
    logic           sel_load;
    logic           sel_hold;
    logic           in_valid;
    logic           in_ready;
    logic [W-1:0]   out_data;
    logic           out_valid;
    logic           out_ready;
    logic [SW-1:0]  out_sel;
    logic           sel_err;

    modport master (
        output in_data, sel, sel_load, sel_hold, in_valid, out_ready,
        input  in_ready, out_data, out_valid, out_sel, sel_err
    );

    modport slave (
        input  in_data, sel, sel_load, sel_hold, in_valid, out_ready,
        output in_ready, out_data, out_valid, out_sel, sel_err
    );

endinterface

// File: rtl/mux_n_pipe_comb.sv
// Purely combinational N-way, W-bit selector; out-of-range selectors yield DEFAULT_VAL.
module mux_n_comb
    import mux_pkg::*;
#(
    parameter int             W           = 32,
    parameter int             N           = 5,
    parameter logic [W-1:0]   DEFAULT_VAL = W'(DEFAULT_VAL_C)
) (
    input  logic [N*W-1:0]          in_data,
    input  logic [sel_width(N)-1:0] sel,
    output logic [W-1:0]            out_data
);
    localparam int SW = sel_width(N);

    // Explicit compare per input so codes >= N can never alias a real input.
    always_comb begin
        out_data = DEFAULT_VAL;
        for (int k = 0; k < N; k++) begin
            if (sel == SW'(k)) out_data = in_data[k*W +: W];
        end
    end

endmodule

// File: rtl/mux_n_pipe.sv
// Registered N-way selector with valid/ready handshake and latchable selector.
// Optional sticky out-of-range flag enabled by defining MUX_SEL_CHECK_EN.
module mux_n_pipe
    import mux_pkg::*;
#(
    parameter int           W           = 32,
    parameter int           N           = 5,
    parameter logic [W-1:0] DEFAULT_VAL = W'(DEFAULT_VAL_C)
) (
    input  logic         clk,
    input  logic         reset,
    mux_n_pipe_if.slave  bus
);
    localparam int SW = sel_width(N);

    logic [SW-1:0] sel_q;
    logic [SW-1:0] eff_sel;
    logic [W-1:0]  sel_data;
    logic          accept;
    logic          vld_p1;
    logic [W-1:0]  out_data_p1;
    logic [SW-1:0] out_sel_p1;
    logic          sel_err_q;
    pipe_state_e   state_q, state_d;

    // A load in the same cycle as hold still uses the previous sel_q.
    assign eff_sel = bus.sel_hold ? sel_q : bus.sel;

    mux_n_comb #(
        .W           (W),
        .N           (N),
        .DEFAULT_VAL (DEFAULT_VAL)
    ) u_comb (
        .in_data  (bus.in_data),
        .sel      (eff_sel),
        .out_data (sel_data)
    );

    always_comb begin
        state_d      = state_q;
        bus.in_ready = reset && ((state_q == EMPTY) || bus.out_ready);
        accept       = bus.in_valid && bus.in_ready;
        case (state_q)
            EMPTY: if (accept) state_d = FULL;
            FULL: begin
                if (accept)             state_d = FULL;
                else if (bus.out_ready) state_d = EMPTY;
            end
            default: state_d = EMPTY;
        endcase
    end

    assign vld_p1 = (state_q == FULL);

    // Stage p1: output register, updated only on accept so stalls hold data.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= EMPTY;
            sel_q       <= '0;
            out_data_p1 <= DEFAULT_VAL;
            out_sel_p1  <= '0;
        end else begin
            state_q <= state_d;
            if (bus.sel_load) sel_q <= bus.sel;
            if (accept) begin
                out_data_p1 <= sel_data;
                out_sel_p1  <= eff_sel;
            end
        end
    end

`ifdef MUX_SEL_CHECK_EN
    logic eff_oob;
    logic load_oob;

    assign eff_oob  = (32'(eff_sel) >= 32'(N));
    assign load_oob = (32'(bus.sel) >= 32'(N));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) sel_err_q <= 1'b0;
        else if ((accept && eff_oob) || (bus.sel_load && load_oob)) sel_err_q <= 1'b1;
    end
`else
    assign sel_err_q = 1'b0;
`endif

    assign bus.out_data  = out_data_p1;
    assign bus.out_valid = vld_p1;
    assign bus.out_sel   = out_sel_p1;
    assign bus.sel_err   = sel_err_q;

endmodule

// File: tb/tb_mux_n_pipe.sv
// Directed bench for mux_n_pipe (N=5, W=32) with hand-computed expectations.
module tb_mux_n_pipe;
    localparam int W = 32;
    localparam int N = 5;
`ifdef MUX_SEL_CHECK_EN
    localparam logic EXP_ERR = 1'b1;
`else
    localparam logic EXP_ERR = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;
    int   total = 0;
    int   bad   = 0;

    mux_n_pipe_if #(.W(W), .N(N)) bus ();

    mux_n_pipe #(.W(W), .N(N)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [2:0] s, input logic v, input logic rdy,
                         input logic ld, input logic hd);
        bus.sel       = s;
        bus.in_valid  = v;
        bus.out_ready = rdy;
        bus.sel_load  = ld;
        bus.sel_hold  = hd;
    endtask

    initial begin
        reset = 1'b0;
        for (int k = 0; k < N; k++) bus.in_data[k*W +: W] = 32'h1000_0000 + k;
        drive(3'd3, 1'b1, 1'b1, 1'b0, 1'b0);

        // Reset held while inputs are active
        #2;
        chk("rst_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("rst_data",  bus.out_data, 32'd0);
        chk("rst_ready", {31'd0, bus.in_ready}, 32'd0);
        chk("rst_sel",   {29'd0, bus.out_sel}, 32'd0);
        chk("rst_err",   {31'd0, bus.sel_err}, 32'd0);
        step(); step();
        chk("rst_hold_valid", {31'd0, bus.out_valid}, 32'd0);
        reset = 1'b1;
        bus.in_valid = 1'b0;
        #1;
        chk("rel_ready", {31'd0, bus.in_ready}, 32'd1);

        // Direct select
        drive(3'd3, 1'b1, 1'b1, 1'b0, 1'b0);
        step();
        chk("dir_valid", {31'd0, bus.out_valid}, 32'd1);
        chk("dir_data",  bus.out_data, 32'h1000_0003);
        chk("dir_sel",   {29'd0, bus.out_sel}, 32'd3);
        drive(3'd1, 1'b0, 1'b1, 1'b0, 1'b0);
        step();
        chk("drain_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("drain_data",  bus.out_data, 32'h1000_0003);

        // Back-to-back with stall on the second output
        drive(3'd0, 1'b1, 1'b1, 1'b0, 1'b0);
        step();
        chk("b2b0_data", bus.out_data, 32'h1000_0000);
        drive(3'd1, 1'b1, 1'b1, 1'b0, 1'b0);
        step();
        chk("b2b1_data", bus.out_data, 32'h1000_0001);
        drive(3'd2, 1'b1, 1'b0, 1'b0, 1'b0);
        #1;
        chk("stall_ready", {31'd0, bus.in_ready}, 32'd0);
        step();
        chk("stall1_data",  bus.out_data, 32'h1000_0001);
        chk("stall1_valid", {31'd0, bus.out_valid}, 32'd1);
        step();
        chk("stall2_data", bus.out_data, 32'h1000_0001);
        bus.out_ready = 1'b1;
        #1;
        chk("unstall_ready", {31'd0, bus.in_ready}, 32'd1);
        step();
        chk("b2b2_data",  bus.out_data, 32'h1000_0002);
        chk("b2b2_valid", {31'd0, bus.out_valid}, 32'd1);
        drive(3'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        step();
        chk("b2b_end_valid", {31'd0, bus.out_valid}, 32'd0);

        // Latched select held across three transfers
        drive(3'd4, 1'b0, 1'b1, 1'b1, 1'b0);
        step();
        for (int i = 0; i < 3; i++) begin
            drive(3'd0, 1'b1, 1'b1, 1'b0, 1'b1);
            step();
            chk($sformatf("hold%0d_data", i), bus.out_data, 32'h1000_0004);
            chk($sformatf("hold%0d_sel", i), {29'd0, bus.out_sel}, 32'd4);
        end
        // Load during hold: this cycle still uses old sel_q
        drive(3'd1, 1'b1, 1'b1, 1'b1, 1'b1);
        step();
        chk("ldhold_old", bus.out_data, 32'h1000_0004);
        drive(3'd0, 1'b1, 1'b1, 1'b0, 1'b1);
        step();
        chk("ldhold_new", bus.out_data, 32'h1000_0001);

        // Out-of-range selectors
        drive(3'd6, 1'b1, 1'b1, 1'b0, 1'b0);
        step();
        chk("oob6_data",  bus.out_data, 32'd0);
        chk("oob6_sel",   {29'd0, bus.out_sel}, 32'd6);
        chk("oob6_valid", {31'd0, bus.out_valid}, 32'd1);
        chk("oob6_err",   {31'd0, bus.sel_err}, {31'd0, EXP_ERR});
        drive(3'd5, 1'b1, 1'b1, 1'b0, 1'b0);
        step();
        chk("oob5_data", bus.out_data, 32'd0);
        drive(3'd2, 1'b1, 1'b1, 1'b0, 1'b0);
        step();
        chk("after_oob_data", bus.out_data, 32'h1000_0002);
        chk("sticky_err", {31'd0, bus.sel_err}, {31'd0, EXP_ERR});

        // Reset asserted mid-stall, between edges
        drive(3'd1, 1'b1, 1'b1, 1'b0, 1'b0);
        step();
        drive(3'd1, 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        chk("pre_rst_valid", {31'd0, bus.out_valid}, 32'd1);
        #2;
        reset = 1'b0;
        #1;
        chk("mid_rst_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("mid_rst_data",  bus.out_data, 32'd0);
        chk("mid_rst_ready", {31'd0, bus.in_ready}, 32'd0);
        chk("mid_rst_err",   {31'd0, bus.sel_err}, 32'd0);
        step();
        reset = 1'b1;
        drive(3'd3, 1'b1, 1'b1, 1'b0, 1'b1);
        step();
        chk("selq_cleared_data", bus.out_data, 32'h1000_0000);
        chk("selq_cleared_sel",  {29'd0, bus.out_sel}, 32'd0);

        // Out-of-range load with no transfer
        drive(3'd7, 1'b0, 1'b1, 1'b1, 1'b0);
        step();
        bus.sel_load = 1'b0;
        chk("ld_oob_err",   {31'd0, bus.sel_err}, {31'd0, EXP_ERR});
        chk("ld_oob_valid", {31'd0, bus.out_valid}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
